// File: rtl/system_pkg.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : system_pkg                                                 |
// | Description : Shared bus widths, machine-timer register offsets, the     |
// |               timer control struct, FSM state type and byte-lane helpers.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

package system_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int MTIME_W    = 64;
    localparam int PRESCALE_W = 16;

    // Machine timer register byte offsets inside the slave window
    localparam logic [7:0] TIMER_MTIME_LO    = 8'h00;
    localparam logic [7:0] TIMER_MTIME_HI    = 8'h04;
    localparam logic [7:0] TIMER_MTIMECMP_LO = 8'h08;
    localparam logic [7:0] TIMER_MTIMECMP_HI = 8'h0C;
    localparam logic [7:0] TIMER_CTRL        = 8'h10;
    localparam logic [7:0] TIMER_PRESCALE    = 8'h14;

    // CTRL layout: bit0 = en, bit1 = ie
    typedef struct packed {
        logic ie;
        logic en;
    } timer_ctrl_t;

    // ERROR response sequencer
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } timer_err_state_t;

    // Byte strobes from the low address bits and the AHB transfer size
    function automatic logic [STRB_WIDTH-1:0] lane_strobe(
        input logic [1:0] addr_lo,
        input logic [1:0] size
    );
        logic [STRB_WIDTH-1:0] strb;
        case (size)
            2'b00:   strb = 4'b0001 << addr_lo;
            2'b01:   strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Replace only the strobed bytes of the old value
    function automatic logic [DATA_WIDTH-1:0] byte_merge(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [DATA_WIDTH-1:0] res;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : timer_prescaler                                            |
// | Description : Divides the timer clock: emits a one-cycle tick each time  |
// |               the counter equals the limit, then restarts from zero.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module timer_prescaler #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    output logic             tick
);

    logic [WIDTH-1:0] count;

    // A limit of zero yields a tick on every enabled cycle
    assign tick = en && (count == limit);

    // Count while enabled; disable, limit rewrite or tick restarts at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!en || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ahbl_timer.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : ahbl_timer                                                 |
// | Description : AHB-Lite slave holding a 64-bit RISC-V machine timer       |
// |               (mtime/mtimecmp), CTRL and the level timer interrupt.      |
// |               Unmapped offsets get a two-cycle ERROR response.           |
// |               Optional macro TIMER_PRESCALE_EN adds PRESCALE at 0x14.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module ahbl_timer
    import system_pkg::*;
#(
    parameter int BASE_OFFSET_W = 5
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rstn_i,
    input  logic                  hsel_i,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  logic [1:0]            htrans_i,
    input  logic                  hwrite_i,
    input  logic [2:0]            hsize_i,
    input  logic [DATA_WIDTH-1:0] hwdata_i,
    input  logic                  hready_i,
    output logic                  hreadyout_o,
    output logic                  hresp_o,
    output logic [DATA_WIDTH-1:0] hrdata_o,
    output logic                  irq_timer_o
);

    // Word-aligned offsets of each register within the window
    localparam logic [BASE_OFFSET_W-1:0] OFF_MTIME_LO    = BASE_OFFSET_W'(TIMER_MTIME_LO);
    localparam logic [BASE_OFFSET_W-1:0] OFF_MTIME_HI    = BASE_OFFSET_W'(TIMER_MTIME_HI);
    localparam logic [BASE_OFFSET_W-1:0] OFF_MTIMECMP_LO = BASE_OFFSET_W'(TIMER_MTIMECMP_LO);
    localparam logic [BASE_OFFSET_W-1:0] OFF_MTIMECMP_HI = BASE_OFFSET_W'(TIMER_MTIMECMP_HI);
    localparam logic [BASE_OFFSET_W-1:0] OFF_CTRL        = BASE_OFFSET_W'(TIMER_CTRL);
    localparam logic [BASE_OFFSET_W-1:0] OFF_PRESCALE    = BASE_OFFSET_W'(TIMER_PRESCALE);

    // True when a word offset addresses an implemented register
    function automatic logic word_mapped(input logic [BASE_OFFSET_W-1:0] word);
`ifdef TIMER_PRESCALE_EN
        return word <= OFF_PRESCALE;
`else
        return word <= OFF_CTRL;
`endif
    endfunction

    // Address phase
    logic                     addr_phase;
    logic [BASE_OFFSET_W-1:0] req_word;
    logic                     req_unmapped;

    // Registered data phase context
    logic                     dp_valid;
    logic                     dp_write;
    logic [1:0]               dp_size;
    logic [BASE_OFFSET_W-1:0] dp_offset;
    logic [BASE_OFFSET_W-1:0] dp_word;
    logic [STRB_WIDTH-1:0]    dp_strb;
    logic                     dp_read;

    // Register file
    logic [MTIME_W-1:0]       mtime;
    logic [MTIME_W-1:0]       mtimecmp;
    timer_ctrl_t              ctrl;
    logic                     tick;

    // Write strobes per register
    logic                     wr_mtime_lo;
    logic                     wr_mtime_hi;
    logic                     wr_mtimecmp_lo;
    logic                     wr_mtimecmp_hi;
    logic                     wr_ctrl;
    logic [DATA_WIDTH-1:0]    ctrl_wr_val;

    // Error sequencer
    timer_err_state_t         state;
    timer_err_state_t         next_state;

    assign addr_phase   = hsel_i && htrans_i[1] && hready_i;
    assign req_word     = {haddr_i[BASE_OFFSET_W-1:2], 2'b00};
    assign req_unmapped = addr_phase && !word_mapped(req_word);

    assign dp_word = {dp_offset[BASE_OFFSET_W-1:2], 2'b00};
    assign dp_strb = lane_strobe(dp_offset[1:0], dp_size);
    assign dp_read = dp_valid && !dp_write;

    assign wr_mtime_lo    = dp_valid && dp_write && (dp_word == OFF_MTIME_LO);
    assign wr_mtime_hi    = dp_valid && dp_write && (dp_word == OFF_MTIME_HI);
    assign wr_mtimecmp_lo = dp_valid && dp_write && (dp_word == OFF_MTIMECMP_LO);
    assign wr_mtimecmp_hi = dp_valid && dp_write && (dp_word == OFF_MTIMECMP_HI);
    assign wr_ctrl        = dp_valid && dp_write && (dp_word == OFF_CTRL);
    assign ctrl_wr_val    = byte_merge(DATA_WIDTH'(ctrl), hwdata_i, dp_strb);

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0]    prescale;
    logic                     wr_prescale;
    logic [DATA_WIDTH-1:0]    prescale_wr_val;

    assign wr_prescale     = dp_valid && dp_write && (dp_word == OFF_PRESCALE);
    assign prescale_wr_val = byte_merge(DATA_WIDTH'(prescale), hwdata_i, dp_strb);

    // PRESCALE register; a rewrite also restarts the divider
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            prescale <= '0;
        end else if (wr_prescale) begin
            prescale <= prescale_wr_val[PRESCALE_W-1:0];
        end
    end

    timer_prescaler #(
        .WIDTH (PRESCALE_W)
    ) u_prescaler (
        .clk   (sys_clk_i),
        .rst_n (sys_rstn_i),
        .en    (ctrl.en),
        .clear (wr_prescale),
        .limit (prescale),
        .tick  (tick)
    );

    logic unused_bits;
    assign unused_bits = &{1'b0, haddr_i[ADDR_WIDTH-1:BASE_OFFSET_W], htrans_i[0],
                           hsize_i[2], ctrl_wr_val[DATA_WIDTH-1:2],
                           prescale_wr_val[DATA_WIDTH-1:PRESCALE_W]};
`else
    // Without the divider the counter advances every enabled cycle
    assign tick = ctrl.en;

    logic unused_bits;
    assign unused_bits = &{1'b0, haddr_i[ADDR_WIDTH-1:BASE_OFFSET_W], htrans_i[0],
                           hsize_i[2], ctrl_wr_val[DATA_WIDTH-1:2]};
`endif

    // Capture the address phase; the valid flag lasts only the data phase
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_size   <= 2'b00;
            dp_offset <= '0;
        end else if (addr_phase) begin
            dp_valid  <= 1'b1;
            dp_write  <= hwrite_i;
            dp_size   <= hsize_i[1:0];
            dp_offset <= haddr_i[BASE_OFFSET_W-1:0];
        end else begin
            dp_valid  <= 1'b0;
        end
    end

    // mtime: a bus write to either half drops that cycle's increment
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            mtime <= '0;
        end else if (wr_mtime_lo || wr_mtime_hi) begin
            if (wr_mtime_lo) begin
                mtime[DATA_WIDTH-1:0] <= byte_merge(mtime[DATA_WIDTH-1:0], hwdata_i, dp_strb);
            end
            if (wr_mtime_hi) begin
                mtime[MTIME_W-1:DATA_WIDTH] <=
                    byte_merge(mtime[MTIME_W-1:DATA_WIDTH], hwdata_i, dp_strb);
            end
        end else if (tick) begin
            mtime <= mtime + MTIME_W'(1);
        end
    end

    // mtimecmp and CTRL byte-lane writes
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            mtimecmp <= '1;
            ctrl     <= '0;
        end else begin
            if (wr_mtimecmp_lo) begin
                mtimecmp[DATA_WIDTH-1:0] <=
                    byte_merge(mtimecmp[DATA_WIDTH-1:0], hwdata_i, dp_strb);
            end
            if (wr_mtimecmp_hi) begin
                mtimecmp[MTIME_W-1:DATA_WIDTH] <=
                    byte_merge(mtimecmp[MTIME_W-1:DATA_WIDTH], hwdata_i, dp_strb);
            end
            if (wr_ctrl) begin
                ctrl <= timer_ctrl_t'(ctrl_wr_val[1:0]);
            end
        end
    end

    // Level interrupt registered from the current compare
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            irq_timer_o <= 1'b0;
        end else begin
            irq_timer_o <= ctrl.ie && (mtime >= mtimecmp);
        end
    end

    // Read data driven only during a read data phase
    always_comb begin
        hrdata_o = '0;
        if (dp_read) begin
            case (dp_word)
                OFF_MTIME_LO:    hrdata_o = mtime[DATA_WIDTH-1:0];
                OFF_MTIME_HI:    hrdata_o = mtime[MTIME_W-1:DATA_WIDTH];
                OFF_MTIMECMP_LO: hrdata_o = mtimecmp[DATA_WIDTH-1:0];
                OFF_MTIMECMP_HI: hrdata_o = mtimecmp[MTIME_W-1:DATA_WIDTH];
                OFF_CTRL:        hrdata_o = DATA_WIDTH'(ctrl);
`ifdef TIMER_PRESCALE_EN
                OFF_PRESCALE:    hrdata_o = DATA_WIDTH'(prescale);
`endif
                default:         hrdata_o = '0;
            endcase
        end
    end

    // Error sequencer state register
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Error sequencer next state and response outputs
    always_comb begin
        next_state  = state;
        hreadyout_o = 1'b1;
        hresp_o     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_unmapped) begin
                    next_state = ST_ERR1;
                end
            end
            ST_ERR1: begin
                hreadyout_o = 1'b0;
                hresp_o     = 1'b1;
                next_state  = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_o     = 1'b1;
                // A transfer started here is decoded like any other
                next_state  = req_unmapped ? ST_ERR1 : ST_IDLE;
            end
            default: begin
                next_state  = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ahbl_timer.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : tb_ahbl_timer                                              |
// | Description : Directed self-checking bench for ahbl_timer.               |
// |               Honours TIMER_PRESCALE_EN for the prescaler scenario.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_ahbl_timer;

    logic        clk;
    logic        rst_n;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Single slave on the bus: ready loops back from the slave
    assign hready = hreadyout;

    ahbl_timer #(
        .BASE_OFFSET_W (5)
    ) dut (
        .sys_clk_i   (clk),
        .sys_rstn_i  (rst_n),
        .hsel_i      (hsel),
        .haddr_i     (haddr),
        .htrans_i    (htrans),
        .hwrite_i    (hwrite),
        .hsize_i     (hsize),
        .hwdata_i    (hwdata),
        .hready_i    (hready),
        .hreadyout_o (hreadyout),
        .hresp_o     (hresp),
        .hrdata_o    (hrdata),
        .irq_timer_o (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single write; returns #1 after the edge that commits the data
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [2:0] size);
        hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = 1'b1; hsize = size;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = data;
        @(posedge clk); #1;
    endtask

    // Single word read; data sampled mid data phase
    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = 1'b0; hsize = 3'b010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        data = hrdata;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        n_checks++; if (hreadyout !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout: got %b expected 1", hreadyout); end
        n_checks++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL reset_hresp: got %b expected 0", hresp); end
        n_checks++; if (hrdata !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata: got %h expected 0", hrdata); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        bus_read(32'h08, d);
        n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_cmp_lo: got %h expected ffffffff", d); end
        bus_read(32'h0C, d);
        n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_cmp_hi: got %h expected ffffffff", d); end
        bus_read(32'h10, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", d); end
        bus_read(32'h00, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mtime_lo: got %h expected 0", d); end
        bus_read(32'h04, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mtime_hi: got %h expected 0", d); end
    endtask

    task automatic test_count_irq;
        logic [31:0] d;
        int first;
        bus_write(32'h08, 32'h20, 3'b010);
        bus_write(32'h0C, 32'h0, 3'b010);
        bus_write(32'h10, 32'h3, 3'b010);
        // mtime is 0 here and reaches 0x20 after 32 edges
        first = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (irq === 1'b1 && first == 0) first = k;
        end
        n_checks++; if (first !== 33) begin n_fail++; $display("FAIL irq_rise_cycle: got %0d expected 33", first); end
        bus_read(32'h00, d);
        n_checks++; if (d !== 32'h29) begin n_fail++; $display("FAIL count_mtime_lo: got %h expected 00000029", d); end
        bus_write(32'h0C, 32'h1, 3'b010);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold: got %b expected 1", irq); end
        @(posedge clk); #1;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b expected 0", irq); end
        bus_write(32'h10, 32'h0, 3'b010);
    endtask

    task automatic test_carry_wrap;
        logic [31:0] d;
        bus_write(32'h04, 32'hFFFF_FFFF, 3'b010);
        bus_write(32'h00, 32'hFFFF_FFFE, 3'b010);
        bus_write(32'h10, 32'h1, 3'b010);
        bus_read(32'h00, d);
        n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_lo_ff: got %h expected ffffffff", d); end
        bus_read(32'h04, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL wrap_hi_zero: got %h expected 0", d); end
        bus_read(32'h00, d);
        n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL wrap_lo_after: got %h expected 00000003", d); end
        // Write while counting: write wins, then carry into HI
        bus_write(32'h00, 32'hFFFF_FFFF, 3'b010);
        bus_read(32'h04, d);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL carry_hi: got %h expected 00000001", d); end
        bus_read(32'h00, d);
        n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL carry_lo: got %h expected 00000002", d); end
        bus_write(32'h10, 32'h0, 3'b010);
    endtask

    task automatic test_byte_lane;
        logic [31:0] d;
        bus_write(32'h08, 32'h1122_3344, 3'b010);
        bus_write(32'h09, 32'h0000_AB00, 3'b000);
        bus_read(32'h08, d);
        n_checks++; if (d !== 32'h1122_AB44) begin n_fail++; $display("FAIL byte_write: got %h expected 1122ab44", d); end
        bus_write(32'h0A, 32'h5566_0000, 3'b001);
        bus_read(32'h08, d);
        n_checks++; if (d !== 32'h5566_AB44) begin n_fail++; $display("FAIL half_write: got %h expected 5566ab44", d); end
    endtask

    task automatic test_unmapped;
        logic [31:0] d;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h1C; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hDEAD_BEEF;
        n_checks++; if ({hreadyout, hresp} !== 2'b01) begin n_fail++; $display("FAIL unmapped_err1: got %b expected 01", {hreadyout, hresp}); end
        @(posedge clk); #1;
        n_checks++; if ({hreadyout, hresp} !== 2'b11) begin n_fail++; $display("FAIL unmapped_err2: got %b expected 11", {hreadyout, hresp}); end
        @(posedge clk); #1;
        n_checks++; if ({hreadyout, hresp} !== 2'b10) begin n_fail++; $display("FAIL unmapped_idle: got %b expected 10", {hreadyout, hresp}); end
        bus_read(32'h08, d);
        n_checks++; if (d !== 32'h5566_AB44) begin n_fail++; $display("FAIL unmapped_cmp_lo: got %h expected 5566ab44", d); end
        bus_read(32'h0C, d);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL unmapped_cmp_hi: got %h expected 00000001", d); end
        bus_read(32'h10, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_ctrl: got %h expected 0", d); end
    endtask

    task automatic test_back_to_back;
        // Unmapped read followed by a read issued during ERR2
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h18; hwrite = 1'b0; hsize = 3'b010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        n_checks++; if (hrdata !== 32'h0) begin n_fail++; $display("FAIL err_rdata: got %h expected 0", hrdata); end
        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h08; hwrite = 1'b0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        n_checks++; if ({hreadyout, hresp} !== 2'b10) begin n_fail++; $display("FAIL b2b_after_err_resp: got %b expected 10", {hreadyout, hresp}); end
        n_checks++; if (hrdata !== 32'h5566_AB44) begin n_fail++; $display("FAIL b2b_after_err_data: got %h expected 5566ab44", hrdata); end
        @(posedge clk); #1;
        // Pipelined write, write, read, read
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h08; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk); #1;
        haddr = 32'h0C; hwdata = 32'hA5A5_0001;
        @(posedge clk); #1;
        haddr = 32'h08; hwrite = 1'b0; hwdata = 32'h0000_0002;
        @(posedge clk); #1;
        haddr = 32'h0C;
        n_checks++; if (hrdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL b2b_cmp_lo: got %h expected a5a50001", hrdata); end
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        n_checks++; if (hrdata !== 32'h2) begin n_fail++; $display("FAIL b2b_cmp_hi: got %h expected 00000002", hrdata); end
        @(posedge clk); #1;
    endtask

`ifdef TIMER_PRESCALE_EN
    task automatic test_prescale;
        logic [31:0] d;
        logic [31:0] exp_seq [5];
        exp_seq[0] = 32'd0; exp_seq[1] = 32'd0; exp_seq[2] = 32'd1;
        exp_seq[3] = 32'd1; exp_seq[4] = 32'd2;
        bus_write(32'h00, 32'h0, 3'b010);
        bus_write(32'h04, 32'h0, 3'b010);
        bus_write(32'h14, 32'h3, 3'b010);
        bus_write(32'h10, 32'h1, 3'b010);
        for (int i = 0; i < 5; i++) begin
            bus_read(32'h00, d);
            n_checks++; if (d !== exp_seq[i]) begin n_fail++; $display("FAIL prescale_mtime[%0d]: got %h expected %h", i, d, exp_seq[i]); end
        end
        bus_write(32'h10, 32'h0, 3'b010);
        bus_read(32'h14, d);
        n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL prescale_readback: got %h expected 00000003", d); end
    endtask
`else
    task automatic test_prescale;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h14; hwrite = 1'b0; hsize = 3'b010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        n_checks++; if ({hreadyout, hresp} !== 2'b01) begin n_fail++; $display("FAIL prescale_err1: got %b expected 01", {hreadyout, hresp}); end
        @(posedge clk); #1;
        n_checks++; if ({hreadyout, hresp} !== 2'b11) begin n_fail++; $display("FAIL prescale_err2: got %b expected 11", {hreadyout, hresp}); end
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_reset_mid;
        logic [31:0] d;
        bus_write(32'h08, 32'h0, 3'b010);
        bus_write(32'h0C, 32'h0, 3'b010);
        bus_write(32'h10, 32'h2, 3'b010);
        @(posedge clk); #1;
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mid_irq_set: got %b expected 1", irq); end
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h1C; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        n_checks++; if (hreadyout !== 1'b0) begin n_fail++; $display("FAIL mid_in_err1: got %b expected 0", hreadyout); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({hreadyout, hresp} !== 2'b10) begin n_fail++; $display("FAIL mid_reset_resp: got %b expected 10", {hreadyout, hresp}); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_reset_irq: got %b expected 0", irq); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_read(32'h10, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_ctrl: got %h expected 0", d); end
        bus_read(32'h08, d);
        n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mid_cmp_lo: got %h expected ffffffff", d); end
        bus_read(32'h00, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_mtime_lo: got %h expected 0", d); end
    endtask

    initial begin
        rst_n  = 1'b0;
        hsel   = 1'b0;
        haddr  = 32'h0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'b010;
        hwdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset;
        test_count_irq;
        test_carry_wrap;
        test_byte_lane;
        test_unmapped;
        test_back_to_back;
        test_prescale;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
